// File: rtl/mcf_pkg.sv
// Shared types and constants for the multi-channel glitch filter / period monitor.
package mcf_pkg;

  // All-ones reference; each channel slices its own period width out of it.
  localparam logic [63:0] PER_MAX = '1;

  // Per-channel single-bit status, packed so the top can index it per lane.
  typedef struct packed {
    logic filt;
    logic raw_rise;
    logic filt_rise;
    logic filt_fall;
    logic period_vld;
    logic stalled;
  } mcf_flags_t;

  // Stability threshold: short one for simulation, full counter range otherwise.
  // Widths are expected below 32.
  function automatic int unsigned stbl_thresh(input int fast_sim, input int stbl_w,
                                              input int fast_w);
    if (fast_sim != 0) return (32'd1 << fast_w) - 32'd1;
    return (32'd1 << stbl_w) - 32'd1;
  endfunction

endpackage

// File: rtl/mcf_chan.sv
// One channel: synchroniser, stability filter, filtered edges, rise-to-rise period.
module mcf_chan
  import mcf_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int STBL_W   = 16,
  parameter int FAST_W   = 9,
  parameter int PER_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  output mcf_flags_t       flags_o,
  output logic [PER_W-1:0] period_o
);

  localparam logic [STBL_W-1:0] STBL     = STBL_W'(stbl_thresh(FAST_SIM, STBL_W, FAST_W));
  localparam logic [PER_W-1:0]  PCNT_MAX = PER_W'(PER_MAX);

  // sync_q[0]=q1, sync_q[1]=q2, sync_q[2]=q3 (q3 is the compare/delay stage)
  logic [2:0]        sync_q;
  logic [STBL_W-1:0] cnt_q, cnt_d;
  logic              filt_q, filt_d;
  logic              dly_q;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              vld_q, vld_d;
  logic              seen_q, seen_d;
  logic [PER_W-1:0]  pcnt_q, pcnt_d;
  logic [PER_W-1:0]  period_q, period_d;

  // Next-state: saturating stability count, filtered level, edges, period capture.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[1] != sync_q[2])  cnt_d = '0;
    else if (cnt_q != STBL)      cnt_d = cnt_q + STBL_W'(1);

    // Level only follows the synchronised input once it has been stable long enough.
    filt_d = (cnt_q == STBL) ? sync_q[2] : filt_q;

    rise_d = filt_q & ~dly_q;
    fall_d = ~filt_q & dly_q;
    // The first filtered rise only arms the period measurement.
    vld_d  = rise_d & seen_q;
    seen_d = seen_q | rise_d;

    pcnt_d = pcnt_q;
    if (rise_d)                   pcnt_d = PER_W'(1);
    else if (pcnt_q != PCNT_MAX)  pcnt_d = pcnt_q + PER_W'(1);

    // A saturated counter is captured as all-ones, which flags a stalled input.
    period_d = vld_d ? pcnt_q : period_q;
  end

  // State registers; reset aborts every count in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      dly_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      vld_q    <= 1'b0;
      seen_q   <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], sig_i};
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      dly_q    <= filt_q;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      vld_q    <= vld_d;
      seen_q   <= seen_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
    end
  end

  assign flags_o.filt       = filt_q;
  assign flags_o.raw_rise   = sync_q[1] & ~sync_q[2];
  assign flags_o.filt_rise  = rise_q;
  assign flags_o.filt_fall  = fall_q;
  assign flags_o.period_vld = vld_q;
  assign flags_o.stalled    = (pcnt_q == PCNT_MAX);
  assign period_o           = period_q;

endmodule

// File: rtl/multi_chan_filt.sv
// N independent glitch-filter / period-monitor channels with packed outputs.
module multi_chan_filt
  import mcf_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int FAST_SIM = 1,
  parameter int STBL_W   = 16,
  parameter int FAST_W   = 9,
  parameter int PER_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sig_in,
  output logic [NUM_CH-1:0]       sig_filt,
  output logic [NUM_CH-1:0]       raw_rise,
  output logic [NUM_CH-1:0]       filt_rise,
  output logic [NUM_CH-1:0]       filt_fall,
  output logic [NUM_CH*PER_W-1:0] period,
  output logic [NUM_CH-1:0]       period_vld,
  output logic [NUM_CH-1:0]       stalled
);

  mcf_flags_t [NUM_CH-1:0] flags;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mcf_chan #(
      .FAST_SIM (FAST_SIM),
      .STBL_W   (STBL_W),
      .FAST_W   (FAST_W),
      .PER_W    (PER_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_i    (sig_in[i]),
      .flags_o  (flags[i]),
      .period_o (period[i*PER_W +: PER_W])
    );

    assign sig_filt[i]   = flags[i].filt;
    assign raw_rise[i]   = flags[i].raw_rise;
    assign filt_rise[i]  = flags[i].filt_rise;
    assign filt_fall[i]  = flags[i].filt_fall;
    assign period_vld[i] = flags[i].period_vld;
    assign stalled[i]    = flags[i].stalled;
  end

endmodule

// File: tb/tb_multi_chan_filt.sv
// Directed bench with a pulse scoreboard for multi_chan_filt (PER_W shortened to 12).
module tb_multi_chan_filt;

  localparam int NUM_CH = 4;
  localparam int PER_W  = 12;
  localparam int LAT    = 515;   // input step at edge 1 -> sig_filt changes at edge 515
  localparam int K_RAW  = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_VLD  = 3;

  typedef struct {
    int     ch;
    int     kind;
    longint cyc;
    longint per;
  } ev_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       sig_in;
  logic [NUM_CH-1:0]       sig_filt, raw_rise, filt_rise, filt_fall, period_vld, stalled;
  logic [NUM_CH*PER_W-1:0] period;

  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  ev_t    exp_q[$];

  multi_chan_filt #(
    .NUM_CH(NUM_CH), .FAST_SIM(1), .STBL_W(16), .FAST_W(9), .PER_W(PER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_filt(sig_filt),
    .raw_rise(raw_rise), .filt_rise(filt_rise), .filt_fall(filt_fall),
    .period(period), .period_vld(period_vld), .stalled(stalled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RAW:   return "raw_rise";
      K_RISE:  return "filt_rise";
      K_FALL:  return "filt_fall";
      default: return "period_vld";
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int c, input int k, input longint at, input longint per);
    ev_t e;
    e.ch = c; e.kind = k; e.cyc = at; e.per = per;
    exp_q.push_back(e);
  endtask

  // Pulse seen on the DUT: find the oldest matching expectation and retire it.
  task automatic match(input int c, input int k, input longint per);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].ch == c && exp_q[i].kind == k) idx = i;
    checks++;
    assert (idx >= 0) else begin
      errors++;
      $error("FAIL unexpected %s ch%0d at cycle %0d: observed 1 expected 0", kname(k), c, cyc);
    end
    if (idx >= 0) begin
      chk($sformatf("ch%0d %s cycle", c, kname(k)), cyc, exp_q[idx].cyc);
      if (k == K_VLD) chk($sformatf("ch%0d period", c), per, exp_q[idx].per);
      exp_q.delete(idx);
    end
  endtask

  // Output monitor: every pulse must have been predicted by the stimulus.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (raw_rise[c])   match(c, K_RAW, 0);
        if (filt_rise[c])  match(c, K_RISE, 0);
        if (filt_fall[c])  match(c, K_FALL, 0);
        if (period_vld[c]) match(c, K_VLD, longint'(period[c*PER_W +: PER_W]));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one channel; a rising raw input shows up on raw_rise two edges later.
  task automatic drive(input int c, input logic v);
    if (v && !sig_in[c]) push(c, K_RAW, cyc + 2, 0);
    sig_in[c] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " sig_filt"},   sig_filt,   0);
    chk({tag, " raw_rise"},   raw_rise,   0);
    chk({tag, " filt_rise"},  filt_rise,  0);
    chk({tag, " filt_fall"},  filt_fall,  0);
    chk({tag, " period_vld"}, period_vld, 0);
    chk({tag, " stalled"},    stalled,    0);
    chk({tag, " period"},     longint'(period), 0);
  endtask

  longint c0, c2, c3;

  initial begin
    rst_n  = 1'b0;
    sig_in = '0;
    wait_clks(3);
    chk_all_zero("in reset");
    rst_n = 1'b1;

    // 1: idle input, nothing moves
    for (int i = 0; i < 10; i++) begin
      wait_clks(100);
      chk_all_zero("idle");
    end

    // 2: clean step on ch0
    c0 = cyc;
    drive(0, 1'b1);
    push(0, K_RISE, c0 + LAT + 1, 0);
    wait_clks(LAT - 1);
    chk("ch0 sig_filt before latency", sig_filt[0], 0);
    wait_clks(1);
    chk("ch0 sig_filt at latency", sig_filt, 4'b0001);
    wait_clks(10);

    // 3: ch1 glitches never pass, then a long pulse gives one rise and one fall
    drive(1, 1'b1); wait_clks(300);
    drive(1, 1'b0); wait_clks(5);
    drive(1, 1'b1); wait_clks(300);
    chk("ch1 glitch sig_filt", sig_filt[1], 0);
    drive(1, 1'b0); wait_clks(600);
    chk("ch1 glitch settled", sig_filt[1], 0);
    c0 = cyc;
    drive(1, 1'b1);
    push(1, K_RISE, c0 + LAT + 1, 0);
    wait_clks(600);
    chk("ch1 long pulse high", sig_filt[1], 1);
    c2 = cyc;
    drive(1, 1'b0);
    push(1, K_FALL, c2 + LAT + 1, 0);
    wait_clks(600);
    chk("ch1 long pulse low", sig_filt[1], 0);

    // 4: ch2 square wave, period 2000
    for (int k = 0; k < 4; k++) begin
      c0 = cyc;
      drive(2, 1'b1);
      push(2, K_RISE, c0 + LAT + 1, 0);
      if (k > 0) push(2, K_VLD, c0 + LAT + 1, 2000);
      wait_clks(1000);
      chk("ch2 stalled mid high", stalled[2], 0);
      drive(2, 1'b0);
      push(2, K_FALL, c0 + 1000 + LAT + 1, 0);
      wait_clks(1000);
      chk("ch2 stalled mid low", stalled[2], 0);
    end
    chk("ch2 period reg", longint'(period[2*PER_W +: PER_W]), 2000);

    // 5: ch3 single rise then held -> stall after 2^PER_W-1 clocks, next rise captures max
    c0 = cyc;
    drive(3, 1'b1);
    push(3, K_RISE, c0 + LAT + 1, 0);
    wait_clks(LAT + 1 + 4093);
    chk("ch3 stalled just before", stalled[3], 0);
    wait_clks(1);
    chk("ch3 stalled asserted", stalled[3], 1);
    wait_clks(100);
    c2 = cyc;
    drive(3, 1'b0);
    push(3, K_FALL, c2 + LAT + 1, 0);
    wait_clks(600);
    c3 = cyc;
    drive(3, 1'b1);
    push(3, K_RISE, c3 + LAT + 1, 0);
    push(3, K_VLD,  c3 + LAT + 1, 4095);
    wait_clks(LAT);
    chk("ch3 stalled until rise", stalled[3], 1);
    wait_clks(1);
    chk("ch3 stalled cleared", stalled[3], 0);
    chk("ch3 period reg", longint'(period[3*PER_W +: PER_W]), 4095);

    // 6: async reset mid-count with all inputs high
    drive(1, 1'b1);
    drive(2, 1'b1);
    wait_clks(200);
    chk("pre-reset sig_filt", sig_filt, 4'b1001);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    wait_clks(3);
    rst_n = 1'b1;
    c0 = cyc;
    for (int c = 0; c < NUM_CH; c++) begin
      push(c, K_RAW,  c0 + 2, 0);
      push(c, K_RISE, c0 + LAT + 1, 0);
    end
    wait_clks(LAT - 1);
    chk("post-reset sig_filt before", sig_filt, 0);
    wait_clks(1);
    chk("post-reset sig_filt", sig_filt, 4'b1111);
    wait_clks(20);
    chk("post-reset period", longint'(period), 0);
    chk("post-reset stalled", stalled, 0);

    // Every predicted pulse must have been consumed.
    chk("pending expected pulses", exp_q.size(), 0);
    foreach (exp_q[i])
      $display("  pending: ch%0d %s at cycle %0d", exp_q[i].ch, kname(exp_q[i].kind), exp_q[i].cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
